// File: rtl/beep_arbiter.sv
// Round-robin arbiter that shares one buzzer between REQ_NUM requesters; requester i gets i+1 beeps.
// Optional macro TONE_PWM_EN: square-wave tone (half-period TONE_DIV) during ON for passive buzzers.
module beep_arbiter #(
    parameter int REQ_NUM  = 3,
    parameter int ON_CYC   = 5_000_000,
    parameter int OFF_CYC  = 5_000_000,
    parameter int GAP_CYC  = 15_000_000,
    parameter int TONE_DIV = 12_500
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic [REQ_NUM-1:0]         req,
    output logic                       beep,
    output logic                       busy,
    output logic [$clog2(REQ_NUM)-1:0] grant_id,
    output logic [REQ_NUM-1:0]         pend
);

    localparam int ID_W    = $clog2(REQ_NUM);
    localparam int MAX_ONF = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int MAX_CYC = (MAX_ONF > GAP_CYC) ? MAX_ONF : GAP_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int REM_W   = $clog2(REQ_NUM + 1);

    if (REQ_NUM < 2 || REQ_NUM > 8) begin : g_bad_req_num
        $error("beep_arbiter: REQ_NUM must be in 2..8");
    end
    if (ON_CYC < 1 || OFF_CYC < 1 || GAP_CYC < 1 || TONE_DIV < 1) begin : g_bad_cyc
        $error("beep_arbiter: ON_CYC, OFF_CYC, GAP_CYC and TONE_DIV must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_GAP
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [REM_W-1:0]   remaining;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    idx;
    logic               found;
    logic               grant;
    logic [REQ_NUM-1:0] grant_mask;
    logic               beep_d;
    logic               busy_d;

    // Round-robin search: first pending index at or after rr_ptr, wrapping.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % REQ_NUM);
            if (!found && pend[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign grant      = (state == S_IDLE) && (|pend);
    assign grant_mask = grant ? (REQ_NUM'(1) << winner) : '0;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (grant) next_state = S_ON;
            S_ON: begin
                if (cnt == CNT_W'(ON_CYC - 1)) begin
                    next_state = (remaining > REM_W'(1)) ? S_OFF : S_GAP;
                end
            end
            S_OFF:  if (cnt == CNT_W'(OFF_CYC - 1)) next_state = S_ON;
            S_GAP:  if (cnt == CNT_W'(GAP_CYC - 1)) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

`ifdef TONE_PWM_EN
    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    logic [TONE_W-1:0] tone_cnt;
    logic [TONE_W-1:0] tone_cnt_d;
`endif

    // Outputs are decoded from next_state so the registered copies line up with state.
    always_comb begin
        busy_d = (next_state != S_IDLE);
`ifdef TONE_PWM_EN
        beep_d     = 1'b0;
        tone_cnt_d = '0;
        if (next_state == S_ON) begin
            if (state != S_ON) begin
                beep_d     = 1'b1;
                tone_cnt_d = '0;
            end else if (tone_cnt == TONE_W'(TONE_DIV - 1)) begin
                beep_d     = ~beep;
                tone_cnt_d = '0;
            end else begin
                beep_d     = beep;
                tone_cnt_d = tone_cnt + 1'b1;
            end
        end
`else
        beep_d = (next_state == S_ON);
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_IDLE;
            beep  <= 1'b0;
            busy  <= 1'b0;
`ifdef TONE_PWM_EN
            tone_cnt <= '0;
`endif
        end else begin
            state <= next_state;
            beep  <= beep_d;
            busy  <= busy_d;
`ifdef TONE_PWM_EN
            tone_cnt <= tone_cnt_d;
`endif
        end
    end

    // A req landing on its own grant edge re-sets pend, queueing one more burst.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend      <= '0;
            rr_ptr    <= '0;
            grant_id  <= '0;
            remaining <= '0;
            cnt       <= '0;
        end else begin
            pend <= (pend & ~grant_mask) | req;
            if (grant) begin
                rr_ptr    <= (winner == ID_W'(REQ_NUM - 1)) ? '0 : winner + 1'b1;
                grant_id  <= winner;
                remaining <= REM_W'(winner) + REM_W'(1);
            end else if (state == S_ON && next_state == S_OFF) begin
                remaining <= remaining - 1'b1;
            end
            if (next_state != state || state == S_IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_beep_arbiter.sv
// Scoreboard bench for beep_arbiter: expected bursts are queued at stimulus time and
// compared against bursts reconstructed from beep/busy/grant_id.
module tb_beep_arbiter;

    localparam int REQ_NUM  = 3;
    localparam int ON_CYC   = 4;
    localparam int OFF_CYC  = 3;
    localparam int GAP_CYC  = 5;
    localparam int TONE_DIV = 1;
`ifdef TONE_PWM_EN
    localparam int   PULSE_PER_ON = ON_CYC / 2;
    localparam int   HIGH_PER_ON  = ON_CYC / 2;
    localparam logic BEEP_ON2_C2  = 1'b0;
`else
    localparam int   PULSE_PER_ON = 1;
    localparam int   HIGH_PER_ON  = ON_CYC;
    localparam logic BEEP_ON2_C2  = 1'b1;
`endif

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [2:0] req       = '0;
    logic       beep;
    logic       busy;
    logic [1:0] grant_id;
    logic [2:0] pend;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] pulses;
        logic [15:0] high;
        logic [15:0] len;
        logic        stable;
    } burst_t;

    burst_t exp_q[$];
    burst_t obs_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int busy_total = 0;
    int idle_beep = 0;

    beep_arbiter #(
        .REQ_NUM (REQ_NUM),
        .ON_CYC  (ON_CYC),
        .OFF_CYC (OFF_CYC),
        .GAP_CYC (GAP_CYC),
        .TONE_DIV(TONE_DIV)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .req      (req),
        .beep     (beep),
        .busy     (busy),
        .grant_id (grant_id),
        .pend     (pend)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Rebuild each burst from the pins, sampled on the falling edge.
    initial begin : monitor
        logic       in_burst;
        logic       prev_beep;
        logic       c_stable;
        logic [1:0] c_id;
        int         c_len, c_pulses, c_high;
        burst_t     b;
        in_burst = 1'b0;
        prev_beep = 1'b0;
        c_stable = 1'b1;
        c_id = '0;
        c_len = 0;
        c_pulses = 0;
        c_high = 0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                in_burst = 1'b0;
            end else if (busy) begin
                if (!in_burst) begin
                    in_burst = 1'b1;
                    c_id = grant_id;
                    c_len = 0;
                    c_pulses = 0;
                    c_high = 0;
                    c_stable = 1'b1;
                    prev_beep = 1'b0;
                end
                c_len++;
                busy_total++;
                if (grant_id !== c_id) c_stable = 1'b0;
                if (beep === 1'b1) c_high++;
                if (beep === 1'b1 && prev_beep !== 1'b1) c_pulses++;
                prev_beep = beep;
            end else begin
                if (beep !== 1'b0) idle_beep++;
                if (in_burst) begin
                    b.id = 8'(c_id);
                    b.pulses = 16'(c_pulses);
                    b.high = 16'(c_high);
                    b.len = 16'(c_len);
                    b.stable = c_stable;
                    obs_q.push_back(b);
                    in_burst = 1'b0;
                end
            end
        end
    end

    function automatic burst_t exp_burst(input int i);
        burst_t b;
        b.id = 8'(i);
        b.pulses = 16'((i + 1) * PULSE_PER_ON);
        b.high = 16'((i + 1) * HIGH_PER_ON);
        b.len = 16'((i + 1) * ON_CYC + i * OFF_CYC + GAP_CYC);
        b.stable = 1'b1;
        return b;
    endfunction

    task automatic do_reset();
        req = '0;
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
        busy_total = 0;
        idle_beep = 0;
    endtask

    task automatic pulse(input logic [2:0] m);
        @(posedge sys_clk);
        #1 req = m;
        @(posedge sys_clk);
        #1 req = '0;
    endtask

    task automatic wait_bursts(input int n, input int budget);
        int c = 0;
        while (obs_q.size() < n && c < budget) begin
            @(posedge sys_clk);
            c++;
        end
        if (obs_q.size() < n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL burst_timeout: got %0d bursts, required %0d", obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (beep !== 1'b0) begin n_fail++; $display("FAIL reset_beep: got %b required 0", beep); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d required 0", grant_id); end
        n_cmp++; if (pend !== 3'b000) begin n_fail++; $display("FAIL reset_pend: got %b required 000", pend); end
        repeat (5) @(posedge sys_clk);
        #1;
        n_cmp++; if (busy !== 1'b0 || beep !== 1'b0) begin n_fail++; $display("FAIL reset_quiet: got busy=%b beep=%b required 0/0", busy, beep); end
    endtask

    task automatic test_single();
        burst_t e, o;
        do_reset();
        @(posedge sys_clk);
        #1 req = 3'b010;
        exp_q.push_back(exp_burst(1));
        @(posedge sys_clk);
        #1 req = '0;
        n_cmp++; if (pend !== 3'b010 || busy !== 1'b0) begin n_fail++; $display("FAIL single_e0: got pend=%b busy=%b required 010/0", pend, busy); end
        @(posedge sys_clk);
        #1;
        n_cmp++; if (busy !== 1'b1 || grant_id !== 2'd1) begin n_fail++; $display("FAIL single_e1_grant: got busy=%b id=%0d required 1/1", busy, grant_id); end
        n_cmp++; if (beep !== 1'b1 || pend !== 3'b000) begin n_fail++; $display("FAIL single_e1_beep: got beep=%b pend=%b required 1/000", beep, pend); end
        repeat (15) @(posedge sys_clk);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_e16_busy: got %b required 1", busy); end
        @(posedge sys_clk);
        #1;
        n_cmp++; if (busy !== 1'b0 || pend !== 3'b000) begin n_fail++; $display("FAIL single_e17_idle: got busy=%b pend=%b required 0/000", busy, pend); end
        wait_bursts(1, 50);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL single_burst: got none, required id=%0d", e.id);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL single_burst: got id=%0d pulses=%0d high=%0d len=%0d stable=%b, required id=%0d pulses=%0d high=%0d len=%0d stable=%b", o.id, o.pulses, o.high, o.len, o.stable, e.id, e.pulses, e.high, e.len, e.stable); end
            end
        end
    endtask

    task automatic test_simultaneous();
        burst_t e, o;
        do_reset();
        pulse(3'b111);
        for (int i = 0; i < 3; i++) exp_q.push_back(exp_burst(i));
        wait_bursts(3, 200);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL simul_burst: got none, required id=%0d", e.id);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL simul_burst: got id=%0d pulses=%0d high=%0d len=%0d stable=%b, required id=%0d pulses=%0d high=%0d len=%0d stable=%b", o.id, o.pulses, o.high, o.len, o.stable, e.id, e.pulses, e.high, e.len, e.stable); end
            end
        end
        n_cmp++; if (busy_total != 48) begin n_fail++; $display("FAIL simul_busy_total: got %0d required 48", busy_total); end
    endtask

    task automatic test_round_robin();
        burst_t e, o;
        do_reset();
        pulse(3'b010);
        exp_q.push_back(exp_burst(1));
        repeat (3) @(posedge sys_clk);
        pulse(3'b101);
        exp_q.push_back(exp_burst(2));
        exp_q.push_back(exp_burst(0));
        n_cmp++; if (pend !== 3'b101 || grant_id !== 2'd1) begin n_fail++; $display("FAIL rr_pend: got pend=%b id=%0d required 101/1", pend, grant_id); end
        wait_bursts(3, 200);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL rr_burst: got none, required id=%0d", e.id);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL rr_burst: got id=%0d pulses=%0d high=%0d len=%0d stable=%b, required id=%0d pulses=%0d high=%0d len=%0d stable=%b", o.id, o.pulses, o.high, o.len, o.stable, e.id, e.pulses, e.high, e.len, e.stable); end
            end
        end
    endtask

    task automatic test_merge_requeue();
        burst_t e, o;
        int c;
        do_reset();
        pulse(3'b010);
        exp_q.push_back(exp_burst(1));
        for (int i = 0; i < 3; i++) pulse(3'b001);
        exp_q.push_back(exp_burst(0));
        n_cmp++; if (pend !== 3'b001) begin n_fail++; $display("FAIL merge_pend: got %b required 001", pend); end
        c = 0;
        while (!(busy === 1'b1 && grant_id === 2'd0) && c < 100) begin
            @(negedge sys_clk);
            c++;
        end
        n_cmp++; if (busy !== 1'b1 || grant_id !== 2'd0) begin n_fail++; $display("FAIL merge_serve0: got busy=%b id=%0d required 1/0", busy, grant_id); end
        pulse(3'b001);
        exp_q.push_back(exp_burst(0));
        n_cmp++; if (pend !== 3'b001) begin n_fail++; $display("FAIL merge_requeue_pend: got %b required 001", pend); end
        wait_bursts(3, 200);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL merge_burst: got none, required id=%0d", e.id);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL merge_burst: got id=%0d pulses=%0d high=%0d len=%0d stable=%b, required id=%0d pulses=%0d high=%0d len=%0d stable=%b", o.id, o.pulses, o.high, o.len, o.stable, e.id, e.pulses, e.high, e.len, e.stable); end
            end
        end
        repeat (40) @(posedge sys_clk);
        #1;
        n_cmp++; if (obs_q.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL merge_no_extra: got bursts=%0d busy=%b required 0/0", obs_q.size(), busy); end
    endtask

    task automatic test_same_edge();
        burst_t e, o;
        do_reset();
        @(posedge sys_clk);
        #1 req = 3'b001;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1 req = '0;
        exp_q.push_back(exp_burst(0));
        exp_q.push_back(exp_burst(0));
        n_cmp++; if (pend !== 3'b001 || busy !== 1'b1) begin n_fail++; $display("FAIL same_edge_pend: got pend=%b busy=%b required 001/1", pend, busy); end
        wait_bursts(2, 100);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL same_edge_burst: got none, required id=%0d", e.id);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL same_edge_burst: got id=%0d pulses=%0d high=%0d len=%0d stable=%b, required id=%0d pulses=%0d high=%0d len=%0d stable=%b", o.id, o.pulses, o.high, o.len, o.stable, e.id, e.pulses, e.high, e.len, e.stable); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge sys_clk);
        #1 req = 3'b100;
        @(posedge sys_clk);
        #1 req = '0;
        @(posedge sys_clk);
        #1;
        n_cmp++; if (grant_id !== 2'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant: got id=%0d busy=%b required 2/1", grant_id, busy); end
        repeat (8) @(posedge sys_clk);
        #1;
        n_cmp++; if (beep !== BEEP_ON2_C2 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_second_on: got beep=%b busy=%b required %b/1", beep, busy, BEEP_ON2_C2); end
        pulse(3'b001);
        #2 sys_rst_n = 1'b0;
        #1;
        n_cmp++; if (beep !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_out: got beep=%b busy=%b required 0/0", beep, busy); end
        n_cmp++; if (pend !== 3'b000 || grant_id !== 2'd0) begin n_fail++; $display("FAIL rstmid_async_state: got pend=%b id=%0d required 000/0", pend, grant_id); end
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        idle_beep = 0;
        repeat (40) @(posedge sys_clk);
        #1;
        n_cmp++; if (idle_beep != 0 || obs_q.size() != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: got idle_beep=%0d bursts=%0d busy=%b required 0/0/0", idle_beep, obs_q.size(), busy); end
    endtask

`ifdef TONE_PWM_EN
    task automatic test_tone();
        logic [3:0] got;
        logic       gap_hi;
        do_reset();
        @(posedge sys_clk);
        #1 req = 3'b001;
        @(posedge sys_clk);
        #1 req = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge sys_clk);
            #1 got[3-i] = beep;
        end
        n_cmp++; if (got !== 4'b1010) begin n_fail++; $display("FAIL tone_on: got %b required 1010", got); end
        gap_hi = 1'b0;
        for (int i = 0; i < GAP_CYC; i++) begin
            @(posedge sys_clk);
            #1 if (beep !== 1'b0 || busy !== 1'b1) gap_hi = 1'b1;
        end
        n_cmp++; if (gap_hi !== 1'b0) begin n_fail++; $display("FAIL tone_gap: got beep/busy deviation=%b required 0", gap_hi); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_merge_requeue();
        test_same_edge();
        test_reset_mid();
`ifdef TONE_PWM_EN
        test_tone();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
